// File: rtl/fifo_nibble_packer.sv
// Pops 4-bit FIFO entries and packs NIB of them LSB-first into one word.
// A flush request emits a partial word with its entry count when the FIFO runs dry.
module fifo_nibble_packer #(
    parameter int DW  = 4,
    parameter int NIB = 4,
    parameter int CW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_e,
    output logic              fifo_re,
    input  logic [DW-1:0]     fifo_out,
    input  logic              flush,
    output logic [DW*NIB-1:0] m_data,
    output logic [CW-1:0]     m_cnt,
    output logic              m_valid,
    input  logic              m_ready
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        OUT
    } state_t;

    state_t              st_q;
    logic [CW-1:0]       idx_q;
    logic [DW*NIB-1:0]   pack_q;
    logic [DW*NIB-1:0]   pack_d;
    logic [DW*NIB-1:0]   data_q;
    logic [CW-1:0]       cnt_q;
    logic                re_q;
    logic                valid_q;

    always_comb begin
        pack_d = pack_q;
        pack_d[idx_q*DW +: DW] = fifo_out;
    end

    // Only IDLE looks at fifo_e, so the post-pop empty flag has settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= IDLE;
            idx_q   <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            re_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (!fifo_e) begin
                        st_q <= READ;
                        re_q <= 1'b1;
                    end else if (flush && idx_q != '0) begin
                        st_q    <= OUT;
                        data_q  <= pack_q;
                        cnt_q   <= idx_q;
                        idx_q   <= '0;
                        pack_q  <= '0;
                        valid_q <= 1'b1;
                    end
                end
                READ: begin
                    re_q <= 1'b0;
                    st_q <= CAPT;
                end
                CAPT: begin
                    if (idx_q == CW'(NIB - 1)) begin
                        st_q    <= OUT;
                        data_q  <= pack_d;
                        cnt_q   <= CW'(NIB);
                        idx_q   <= '0;
                        pack_q  <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        st_q   <= IDLE;
                        pack_q <= pack_d;
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        st_q    <= IDLE;
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    assign fifo_re = re_q;
    assign m_data  = data_q;
    assign m_cnt   = cnt_q;
    assign m_valid = valid_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Directed bench for fifo_nibble_packer with a behavioural 4-bit FIFO.
// Expected words are hand-computed from the pushed entries.
module tb_fifo_nibble_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_e;
    logic        fifo_re;
    logic [3:0]  fifo_out = 4'h0;
    logic        flush = 1'b0;
    logic [15:0] m_data;
    logic [3:0]  m_cnt;
    logic        m_valid;
    logic        m_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [3:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0;
    int cyc = 0;
    int re_cyc [0:63];
    logic uf = 1'b0;
    logic dbl = 1'b0;
    logic re_prev = 1'b0;

    fifo_nibble_packer #(.DW(4), .NIB(4), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo_e   (fifo_e),
        .fifo_re  (fifo_re),
        .fifo_out (fifo_out),
        .flush    (flush),
        .m_data   (m_data),
        .m_cnt    (m_cnt),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    assign fifo_e = (rd_ptr == wr_ptr);

    // FIFO model: data appears one clock after the read-enable edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        re_prev <= fifo_re;
        if (fifo_re && re_prev) dbl <= 1'b1;
        if (fifo_re) begin
            if (rd_ptr == wr_ptr) begin
                uf <= 1'b1;
            end else begin
                fifo_out <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
            re_cyc[pops] <= cyc;
            pops <= pops + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(m_valid), 32'd1);
    endtask

    initial begin
        int base;
        logic seen;
        logic held_bad;

        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_re", 32'(fifo_re), 32'd0);
            check("rst_valid", 32'(m_valid), 32'd0);
            check("rst_data", 32'(m_data), 32'd0);
            check("rst_cnt", 32'(m_cnt), 32'd0);
        end
        base = pops;
        rst = 1'b1;
        #1;
        check("rel_no_re", 32'(fifo_re), 32'd0);

        wait_valid("full_wait");
        check("full_data", 32'(m_data), 32'h4321);
        check("full_cnt", 32'(m_cnt), 32'd4);
        check("full_pops", 32'(pops - base), 32'd4);
        check("full_gap1", 32'(re_cyc[base+1] - re_cyc[base]), 32'd3);
        check("full_gap3", 32'(re_cyc[base+3] - re_cyc[base+2]), 32'd3);
        @(negedge clk);
        check("full_vdrop", 32'(m_valid), 32'd0);
        check("full_dclr", 32'(m_data), 32'd0);
        check("full_empty", 32'(fifo_e), 32'd1);

        base = pops;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(4'(i));
        wait_valid("bp_wait");
        check("bp_data0", 32'(m_data), 32'h4321);
        held_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_valid || m_data != 16'h4321 || m_cnt != 4'd4)
                held_bad = 1'b1;
        end
        check("bp_held", 32'(held_bad), 32'd0);
        check("bp_pops", 32'(pops - base), 32'd4);
        m_ready = 1'b1;
        @(negedge clk);
        wait_valid("bp_wait2");
        check("bp_data1", 32'(m_data), 32'h8765);
        check("bp_cnt1", 32'(m_cnt), 32'd4);
        @(negedge clk);

        base = pops;
        push(4'hA); push(4'hB);
        flush = 1'b1;
        wait_valid("fl_wait");
        check("fl_data", 32'(m_data), 32'h00BA);
        check("fl_cnt", 32'(m_cnt), 32'd2);
        check("fl_pops", 32'(pops - base), 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        check("fl_idx0", 32'(seen), 32'd0);
        flush = 1'b0;

        push(4'h5);
        repeat (6) @(negedge clk);
        check("fd_nov", 32'(m_valid), 32'd0);
        push(4'h6); push(4'h7);
        flush = 1'b1;
        wait_valid("fd_wait");
        check("fd_data", 32'(m_data), 32'h0765);
        check("fd_cnt", 32'(m_cnt), 32'd3);
        @(negedge clk);
        flush = 1'b0;

        base = pops;
        push(4'h9); push(4'hA); push(4'hB); push(4'hC);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ar_re", 32'(fifo_re), 32'd0);
        check("ar_valid", 32'(m_valid), 32'd0);
        check("ar_data", 32'(m_data), 32'd0);
        check("ar_pops", 32'(pops - base), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        push(4'hD); push(4'hE);
        wait_valid("ar_wait");
        check("ar_word", 32'(m_data), 32'hEDCB);
        check("ar_cnt", 32'(m_cnt), 32'd4);
        @(negedge clk);

        m_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_valid("hr_wait");
        check("hr_data", 32'(m_data), 32'h4321);
        #2;
        rst = 1'b0;
        #1;
        check("hr_valid", 32'(m_valid), 32'd0);
        check("hr_dclr", 32'(m_data), 32'd0);
        check("hr_cclr", 32'(m_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("no_underflow", 32'(uf), 32'd0);
        check("no_back2back", 32'(dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_nibble_packer.md
Name: fifo_nibble_packer

Overview:
Read-side consumer for the team's 4-bit FIFO. Pops entries through the FIFO's read-enable/empty interface and packs NIB consecutive entries into one wide word, LSB-first. Presents each word on a valid/ready stream to downstream logic. A flush input emits a partial word, tagged with its entry count, when the FIFO runs dry.

Parameters:
DW, 4, width of one FIFO entry (matches FIFO data width)
NIB, 4, entries packed per output word (2..8)
CW, 4, width of m_cnt; must satisfy 2^CW > NIB

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
fifo_e  input  1  FIFO empty flag
fifo_re  output  1  FIFO read enable, one-cycle pulse per pop
fifo_out  input  DW  FIFO read data, valid one clk after fifo_re pulse
flush  input  1  request emission of a partial word
m_data  output  DW*NIB  packed word; entry k in bits [k*DW +: DW]
m_cnt  output  CW  number of valid entries in m_data (1..NIB)
m_valid  output  1  word available
m_ready  input  1  downstream accepts word when m_valid&&m_ready at rising edge

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, fifo_re=0, m_valid=0, m_data=0, m_cnt=0, packing register cleared. Release is sampled at the next rising edge.
- FSM states: IDLE, READ, CAPT, OUT.
- IDLE:
  - if !fifo_e -> READ.
  - else if flush && idx>0 -> OUT with m_cnt=idx.
  - else stay.
  - !fifo_e has priority over flush.
- READ: fifo_re=1 for exactly this cycle; unconditionally -> CAPT. fifo_re is 0 in every other state. At most one pop is outstanding.
- CAPT: latch fifo_out into slot idx.
  - if idx==NIB-1: m_data<=packed word incl. this entry, m_cnt<=NIB, idx<=0, -> OUT.
  - else idx<=idx+1, -> IDLE.
- Read latency:
  - fifo_out is sampled at the first rising edge after the READ cycle.
  - fifo_e is re-evaluated only in IDLE, one cycle after capture. This guarantees the FIFO's post-pop empty flag is settled.
  - Throughput: one entry per 3 clks; one NIB-word per 3*NIB clks plus handshake.
- OUT:
  - m_valid=1; m_data and m_cnt held stable while m_valid && !m_ready.
  - On m_valid && m_ready: m_valid<=0, packing register cleared, -> IDLE.
  - No FIFO reads in OUT (back-pressure stops draining).
- Partial word (flush): unused upper slots of m_data are 0; idx reset to 0 on entering OUT.
- flush is a level; it is ignored in READ/CAPT/OUT and ignored in IDLE when idx==0 (no empty words are ever emitted).
- m_data changes only on transition into OUT; it is 0 after acceptance until the next word.
- Entry order is preserved: first popped entry lands in bits [DW-1:0].
- Never asserts fifo_re while fifo_e was 1 in the preceding IDLE cycle (no underflow pops).
- Reset mid-operation: any in-flight pop is discarded, partial word lost, outputs return to reset values immediately (async).

Test Plan:
- Reset: rst=0 for 2 clks with FIFO holding data -> fifo_re=0, m_valid=0, m_data=0, m_cnt=0 throughout; first fifo_re no earlier than the 1st rising edge after release.
- Full word: write 1,2,3,4 into FIFO, m_ready=1 -> exactly 4 fifo_re pulses, each followed by 2 idle-re cycles; m_data=16'h4321, m_cnt=4, m_valid high 1 clk; fifo_e=1 afterwards.
- Back-pressure: 8 entries 1..8, m_ready=0 for 10 clks -> m_data=16'h4321 held stable, m_valid=1, only 4 pops; after m_ready=1, second word 16'h8765.
- Flush partial: write A,B then flush=1 with FIFO empty -> m_data=16'h00BA, m_cnt=2; flush with idx=0 -> no m_valid.
- Flush vs data: flush=1 while FIFO non-empty and idx=1 -> pop continues; the word is emitted only when the FIFO is empty or 4 entries are collected.
- Async reset mid-word: assert rst=0 in CAPT after 2 entries -> outputs cleared without a clock edge; next word after release starts at slot 0.
